mem_access_stage: RTL and testbench

Memory-access stage that consumes the EX/MEM pipeline buffer outputs and produces the MEM/WB register contents. It resolves branch and jump redirection and performs loads and stores on an internal word-addressed data memory with a configurable wait-state latency. While an access is in progress it stalls upstream and inserts bubbles into write-back. It sits between the EX/MEM buffer and the write-back mux.

---
 rtl/mem_access_stage_if.sv | 43 ++++
 rtl/mem_access_stage.sv | 97 +++++++++
 tb/tb_mem_access_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// EX/MEM inputs and MEM/WB / redirect outputs of the memory-access stage.
// slave = the stage itself; master = the surrounding pipeline.
interface mem_access_stage_if;
  logic [31:0] i_alu_result;
  logic [31:0] i_read_rb_2;
  logic [31:0] i_branch_address;
  logic [31:0] i_jump_address;
  logic [4:0]  i_inst_mux_br_write_address;
  logic        i_zf;
  logic        i_branch;
  logic        i_jump;
  logic        i_memWrite;
  logic        i_memRead;
  logic        i_regWrite;
  logic        i_memToReg;

  logic        o_stall;
  logic        o_pc_src;
  logic [31:0] o_pc_target;
  logic [31:0] o_wb_data;
  logic [31:0] o_read_data;
  logic [31:0] o_alu_result;
  logic [4:0]  o_write_address;
  logic        o_regWrite;
  logic        o_memToReg;
  logic        o_misaligned;

  modport slave (
    input  i_alu_result, i_read_rb_2, i_branch_address, i_jump_address,
           i_inst_mux_br_write_address, i_zf, i_branch, i_jump,
           i_memWrite, i_memRead, i_regWrite, i_memToReg,
    output o_stall, o_pc_src, o_pc_target, o_wb_data, o_read_data,
           o_alu_result, o_write_address, o_regWrite, o_memToReg, o_misaligned
  );

  modport master (
    output i_alu_result, i_read_rb_2, i_branch_address, i_jump_address,
           i_inst_mux_br_write_address, i_zf, i_branch, i_jump,
           i_memWrite, i_memRead, i_regWrite, i_memToReg,
    input  o_stall, o_pc_src, o_pc_target, o_wb_data, o_read_data,
           o_alu_result, o_write_address, o_regWrite, o_memToReg, o_misaligned
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: branch/jump redirect, wait-stated word memory,
// and the MEM/WB register (bubbles inserted while an access is stalling).
module mem_access_stage #(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_stage_if.slave bus
);

  localparam int unsigned AW       = $clog2(MEM_WORDS);
  localparam logic [3:0]  LAT_M1   = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);
  localparam logic        HAS_WAIT = (MEM_LATENCY != 0);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_q [MEM_WORDS];

  logic          access;
  logic          misaligned;
  logic          stall;
  logic          complete;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   load_data;
  logic [31:0]   wb_data;

  always_comb begin
    access     = bus.i_memRead | bus.i_memWrite;
    misaligned = |bus.i_alu_result[1:0];
    idx        = bus.i_alu_result[AW+1:2];
    stall      = ((state_q == IDLE) && access && HAS_WAIT) ||
                 ((state_q == WAIT) && (cnt_q != '0));
    complete   = ((state_q == WAIT) && (cnt_q == '0)) ||
                 ((state_q == IDLE) && access && !HAS_WAIT);
    mem_we     = complete & bus.i_memWrite & ~misaligned & rst_n;
    // Load sees the word before this edge's store; a write in the same op forces 0.
    load_data  = '0;
    if (bus.i_memRead && !bus.i_memWrite && !misaligned) load_data = mem_q[idx];
    wb_data    = bus.i_memToReg ? load_data : bus.i_alu_result;
  end

  assign bus.o_stall     = stall;
  assign bus.o_pc_src    = ~stall & (bus.i_jump | (bus.i_branch & bus.i_zf));
  assign bus.o_pc_target = bus.i_jump ? bus.i_jump_address : bus.i_branch_address;

  // Memory contents survive reset, so it sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= bus.i_read_rb_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      bus.o_wb_data       <= '0;
      bus.o_read_data     <= '0;
      bus.o_alu_result    <= '0;
      bus.o_write_address <= '0;
      bus.o_regWrite      <= 1'b0;
      bus.o_memToReg      <= 1'b0;
      bus.o_misaligned    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access && HAS_WAIT) begin
            state_q <= WAIT;
            cnt_q   <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q   <= cnt_q - 4'd1;
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (stall) begin
        bus.o_regWrite   <= 1'b0;
        bus.o_memToReg   <= 1'b0;
        bus.o_misaligned <= 1'b0;
      end else begin
        bus.o_wb_data       <= wb_data;
        bus.o_read_data     <= load_data;
        bus.o_alu_result    <= bus.i_alu_result;
        bus.o_write_address <= bus.i_inst_mux_br_write_address;
        bus.o_regWrite      <= bus.i_regWrite;
        bus.o_memToReg      <= bus.i_memToReg;
        bus.o_misaligned    <= access & misaligned;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with MEM_WORDS=64, MEM_LATENCY=2.
module tb_mem_access_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mem_access_stage_if bus ();

  mem_access_stage #(.MEM_WORDS(64), .MEM_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive_nop();
    bus.i_alu_result                = '0;
    bus.i_read_rb_2                 = '0;
    bus.i_branch_address            = '0;
    bus.i_jump_address              = '0;
    bus.i_inst_mux_br_write_address = '0;
    bus.i_zf                        = 1'b0;
    bus.i_branch                    = 1'b0;
    bus.i_jump                      = 1'b0;
    bus.i_memWrite                  = 1'b0;
    bus.i_memRead                   = 1'b0;
    bus.i_regWrite                  = 1'b0;
    bus.i_memToReg                  = 1'b0;
  endtask

  // Presents one memory op, counts stall cycles (bounded), checks bubbles,
  // and returns just after the edge where MEM/WB captures the result.
  task automatic do_access(input string tag, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] dest, input logic m2r, input logic rw);
    int stalls;
    drive_nop();
    bus.i_memWrite                  = we;
    bus.i_memRead                   = re;
    bus.i_alu_result                = addr;
    bus.i_read_rb_2                 = data;
    bus.i_inst_mux_br_write_address = dest;
    bus.i_memToReg                  = m2r;
    bus.i_regWrite                  = rw;
    #1;
    stalls = 0;
    for (int k = 0; k < 20 && bus.o_stall; k++) begin
      stalls++;
      @(posedge clk); #1;
      check({tag, "_bubble_rw"}, {31'd0, bus.o_regWrite}, 32'd0);
    end
    check({tag, "_stall_cycles"}, stalls, 32'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_nop();
    #12;
    check("rst_wb_data",   bus.o_wb_data, 32'd0);
    check("rst_regWrite",  {31'd0, bus.o_regWrite}, 32'd0);
    check("rst_misalign",  {31'd0, bus.o_misaligned}, 32'd0);
    check("rst_stall",     {31'd0, bus.o_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access("st_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
    check("st_10_misalign", {31'd0, bus.o_misaligned}, 32'd0);
    check("st_10_rw",       {31'd0, bus.o_regWrite}, 32'd0);

    drive_nop();
    bus.i_alu_result = 32'h1234;
    bus.i_regWrite   = 1'b1;
    bus.i_inst_mux_br_write_address = 5'd3;
    #1;
    check("alu_stall", {31'd0, bus.o_stall}, 32'd0);
    check("alu_pcsrc", {31'd0, bus.o_pc_src}, 32'd0);
    @(posedge clk); #1;
    check("alu_wb_data", bus.o_wb_data, 32'h1234);
    check("alu_rw",      {31'd0, bus.o_regWrite}, 32'd1);
    check("alu_dest",    {27'd0, bus.o_write_address}, 32'd3);

    do_access("ld_10", 1'b0, 1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1);
    check("ld_10_wb_data", bus.o_wb_data, 32'hDEADBEEF);
    check("ld_10_rdata",   bus.o_read_data, 32'hDEADBEEF);
    check("ld_10_dest",    {27'd0, bus.o_write_address}, 32'd5);
    check("ld_10_rw",      {31'd0, bus.o_regWrite}, 32'd1);
    check("ld_10_m2r",     {31'd0, bus.o_memToReg}, 32'd1);

    drive_nop();
    bus.i_branch = 1'b1; bus.i_zf = 1'b1; bus.i_branch_address = 32'h40;
    #1;
    check("br_pcsrc",  {31'd0, bus.o_pc_src}, 32'd1);
    check("br_target", bus.o_pc_target, 32'h40);
    @(posedge clk); #1;
    bus.i_jump = 1'b1; bus.i_jump_address = 32'h80;
    #1;
    check("jmp_pcsrc",  {31'd0, bus.o_pc_src}, 32'd1);
    check("jmp_target", bus.o_pc_target, 32'h80);
    @(posedge clk); #1;
    drive_nop();
    bus.i_branch = 1'b1; bus.i_zf = 1'b0; bus.i_branch_address = 32'h40;
    #1;
    check("br_nt_pcsrc", {31'd0, bus.o_pc_src}, 32'd0);
    @(posedge clk); #1;

    do_access("st_13", 1'b1, 1'b0, 32'h13, 32'h11111111, 5'd0, 1'b0, 1'b0);
    check("st_13_misalign", {31'd0, bus.o_misaligned}, 32'd1);
    drive_nop();
    @(posedge clk); #1;
    check("st_13_pulse_end", {31'd0, bus.o_misaligned}, 32'd0);
    do_access("ld_10b", 1'b0, 1'b1, 32'h10, 32'h0, 5'd6, 1'b1, 1'b1);
    check("ld_10b_wb_data", bus.o_wb_data, 32'hDEADBEEF);

    do_access("st_100", 1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0);
    do_access("ld_000", 1'b0, 1'b1, 32'h000, 32'h0, 5'd7, 1'b1, 1'b1);
    check("ld_000_wb_data", bus.o_wb_data, 32'hA5A5A5A5);

    drive_nop();
    bus.i_memWrite = 1'b1; bus.i_alu_result = 32'h10; bus.i_read_rb_2 = 32'h0BADF00D;
    #1;
    check("abort_stall", {31'd0, bus.o_stall}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_rst_wb",    bus.o_wb_data, 32'd0);
    check("abort_rst_rdata", bus.o_read_data, 32'd0);
    check("abort_rst_alu",   bus.o_alu_result, 32'd0);
    drive_nop();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle_stall", {31'd0, bus.o_stall}, 32'd0);
    do_access("ld_abort", 1'b0, 1'b1, 32'h10, 32'h0, 5'd9, 1'b1, 1'b1);
    check("ld_abort_wb_data", bus.o_wb_data, 32'hDEADBEEF);
    check("ld_abort_dest",    {27'd0, bus.o_write_address}, 32'd9);

    drive_nop();
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
